port_dev_sched: RTL
===================

# port_dev_sched

Controller-port device scheduler for one SNES controller port. It owns the port's serial interface (latch, clock, data, IOBit/P6) and shares it between four peripheral models: pad, mouse, Super Scope and Justifier. Device changes requested from the OSD are applied only at a safe point, with a forced "unplugged" interval so games see a clean hot-swap. It also provides per-port read statistics (bits clocked since the last latch, latches per frame).

## Interface
Parameters:
- IDLE_CYC, 16'd2048: consecutive quiet CLK cycles (no latch/clock edge, latch low) required before a swap may start.
- SWAP_GAP, 3'd2: number of VDE rising edges the port stays disconnected during a swap; legal range 1..7.
- DEV_RST, 2'd0: device selected after reset.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DEV_REQ  in  2  requested device (0 pad, 1 mouse, 2 scope, 3 justifier); same clock domain; may change at any time.
- DEV_CUR  out  2  device currently owning the port.
- SWAPPING  out  1  high in every state except RUN.
- VDE  in  1  vertical display enable; frame reference.
- PORT_LATCH  in  1  console latch.
- PORT_CLK  in  1  console serial clock.
- PORT_DO  out  2  data returned to the console.
- PORT_P6  out  1  IOBit returned to the console.
- DEV_LATCH  out  4  per-device gated latch, one-hot by device index.
- DEV_CLK  out  4  per-device gated clock.
- DEV_DO  in  8  device data; {DEV_DO[2i+1:2i]} belongs to device i.
- DEV_P6  in  4  device IOBit.
- BIT_CNT  out  6  PORT_CLK rising edges since the last latch; saturates at 63.
- LATCH_PER_FRAME  out  4  latch falling edges counted in the previous frame; saturates at 15.

## Operation
- Edge detection: PORT_LATCH, PORT_CLK and VDE are each registered once; an edge is a mismatch between the registered value and the input.
- Connected (state RUN or WAIT_IDLE):
  - DEV_LATCH[DEV_CUR] = PORT_LATCH and DEV_CLK[DEV_CUR] = PORT_CLK; all other bits are 0.
  - PORT_DO = DEV_DO pair of DEV_CUR; PORT_P6 = DEV_P6[DEV_CUR].
  - All four are combinational, with zero latency.
- Disconnected (state DISC): DEV_LATCH = 0, DEV_CLK = 0, PORT_DO = 2'b00, PORT_P6 = 1.
- The request register req_q samples DEV_REQ every cycle. A pending change means req_q != DEV_CUR and DEV_REQ == req_q, i.e. the request has been stable for 2 cycles.
- State machine:
  - RUN: on a pending change, go to WAIT_IDLE with the idle counter cleared.
  - WAIT_IDLE:
    - The idle counter clears on any latch edge, any clock edge, or while PORT_LATCH = 1; otherwise it increments.
    - If req_q == DEV_CUR (request withdrawn), return to RUN.
    - Else, when the idle counter reaches IDLE_CYC, go to DISC with the gap counter cleared.
  - DISC:
    - The gap counter increments on each VDE rising edge.
    - DEV_REQ changes are ignored for exit decisions in this state.
    - When the gap counter equals SWAP_GAP and PORT_LATCH = 0: load DEV_CUR <= req_q and go to RUN.
    - The swap completes even if req_q now equals the old DEV_CUR.
- BIT_CNT: held at 0 while PORT_LATCH = 1. Otherwise +1 on a PORT_CLK rising edge, saturating at 63. It counts in every state.
- Latch counter:
  - +1 on each PORT_LATCH falling edge, saturating at 15.
  - On a VDE rising edge, LATCH_PER_FRAME <= counter value excluding any same-cycle latch fall.
  - On that VDE rising edge the counter restarts at 1 if a latch fall occurs in the same cycle, else at 0.
- Reset values: state RUN, DEV_CUR = DEV_RST, req_q = DEV_RST, SWAPPING 0, BIT_CNT 0, latch counter 0, LATCH_PER_FRAME 0, idle and gap counters 0, edge registers 0.
- RESET_N asserted mid-swap: return immediately to RUN with DEV_CUR = DEV_RST.

## Timing
- Port pass-through is combinational, with no added cycles.
- Minimum swap latency from a DEV_REQ change with the port already quiet:
  - 2 cycles to RUN->WAIT_IDLE;
  - IDLE_CYC cycles in WAIT_IDLE;
  - then SWAP_GAP VDE rising edges;
  - DEV_CUR updates and SWAPPING falls together in the same cycle.
- Gating changes occur only with PORT_LATCH = 0 and at least IDLE_CYC quiet cycles, so no device ever sees a truncated latch pulse on entry to DISC.
- Exiting DISC: DEV_CUR changes only with PORT_LATCH = 0. The new device's first latch is the console's next full latch pulse.

## Test plan
- Reset, DEV_RST = 0: pulse latch, then 16 clocks with DEV_DO[1:0] toggling.
  - Required: PORT_DO follows DEV_DO[1:0] each cycle.
  - Required: DEV_LATCH = 4'b0001 during the latch; BIT_CNT = 16 at the end.
- DEV_REQ = 2, port quiet, IDLE_CYC = 16, SWAP_GAP = 2:
  - SWAPPING rises 2 cycles after the change.
  - DISC is entered 16 cycles later, with PORT_DO = 00 and PORT_P6 = 1.
  - DEV_CUR = 2 on the cycle of the second VDE rise; DEV_CLK then routes to bit 2.
- DEV_REQ = 3, with latch/clock activity every 10 cycles: state stays WAIT_IDLE and the old device keeps driving.
  - Activity stops -> DISC after 16 quiet cycles.
- DEV_REQ toggles 0->1->0 within WAIT_IDLE: return to RUN and DEV_CUR stays 0, with no disconnect.
  - A single-cycle DEV_REQ glitch never leaves RUN.
- Three latches per frame, then a VDE rise with a latch fall in the same cycle: LATCH_PER_FRAME = 3 and the counter restarts at 1.
  - 20 latches in one frame -> LATCH_PER_FRAME = 15.
  - 70 clocks after a latch -> BIT_CNT = 63.
- RESET_N asserted in DISC with DEV_REQ = 1:
  - Immediately: DEV_CUR = 0 and SWAPPING = 0.
  - After release, with DEV_REQ held at 1, a new swap sequence starts.

Source files
------------

// File: rtl/port_dev_sched.sv
// Controller-port device scheduler: shares one SNES controller port between
// four peripheral models (pad, mouse, Super Scope, Justifier). It hot-swaps
// the owning device only after the port has been quiet for a while, keeps the
// port unplugged for a number of frames, and reports per-port read statistics.
module port_dev_sched #(
  parameter logic [15:0] IDLE_CYC = 16'd2048,
  parameter logic [2:0]  SWAP_GAP = 3'd2,
  parameter logic [1:0]  DEV_RST  = 2'd0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] DEV_REQ,
  output logic [1:0] DEV_CUR,
  output logic       SWAPPING,
  input  logic       VDE,
  input  logic       PORT_LATCH,
  input  logic       PORT_CLK,
  output logic [1:0] PORT_DO,
  output logic       PORT_P6,
  output logic [3:0] DEV_LATCH,
  output logic [3:0] DEV_CLK,
  input  logic [7:0] DEV_DO,
  input  logic [3:0] DEV_P6,
  output logic [5:0] BIT_CNT,
  output logic [3:0] LATCH_PER_FRAME
);

  typedef enum logic [1:0] {RUN, WAIT_IDLE, DISC} state_t;

  state_t      state, state_nxt;
  logic        latch_q, clk_q, vde_q;
  logic [1:0]  req_q;
  logic [1:0]  dev_cur, dev_cur_nxt;
  logic [15:0] idle_cnt, idle_nxt, idle_inc;
  logic [2:0]  gap_cnt, gap_nxt, gap_inc;
  logic [5:0]  bit_cnt;
  logic [3:0]  lat_cnt, lat_per_frame;

  logic latch_edge, latch_fall, clk_edge, clk_rise, vde_rise;
  logic quiet, pending, connected;

  // Edges are a mismatch between the live input and its registered copy.
  assign latch_edge = PORT_LATCH ^ latch_q;
  assign latch_fall = latch_q & ~PORT_LATCH;
  assign clk_edge   = PORT_CLK ^ clk_q;
  assign clk_rise   = PORT_CLK & ~clk_q;
  assign vde_rise   = VDE & ~vde_q;

  // A request is acted on only once it has held the same value for 2 cycles.
  assign pending = (req_q != dev_cur) && (DEV_REQ == req_q);
  assign quiet   = ~latch_edge & ~clk_edge & ~PORT_LATCH;

  assign idle_inc = quiet ? idle_cnt + 16'd1 : 16'd0;
  assign gap_inc  = (vde_rise && gap_cnt != 3'd7) ? gap_cnt + 3'd1 : gap_cnt;

  // Next-state logic: swap only after a quiet port, leave DISC with latch low.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nxt   = state;
    dev_cur_nxt = dev_cur;
    idle_nxt    = idle_cnt;
    gap_nxt     = gap_cnt;
    case (state)
      RUN: begin
        if (pending) begin
          state_nxt = WAIT_IDLE;
          idle_nxt  = 16'd0;
        end
      end
      WAIT_IDLE: begin
        idle_nxt = idle_inc;
        if (req_q == dev_cur) begin
          state_nxt = RUN;
        end else if (idle_inc == IDLE_CYC) begin
          state_nxt = DISC;
          gap_nxt   = 3'd0;
        end
      end
      DISC: begin
        gap_nxt = gap_inc;
        if (gap_inc >= SWAP_GAP && !PORT_LATCH) begin
          state_nxt   = RUN;
          dev_cur_nxt = req_q;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State, ownership, request and edge registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= RUN;
      dev_cur  <= DEV_RST;
      req_q    <= DEV_RST;
      idle_cnt <= 16'd0;
      gap_cnt  <= 3'd0;
      latch_q  <= 1'b0;
      clk_q    <= 1'b0;
      vde_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state    <= state_nxt;
      dev_cur  <= dev_cur_nxt;
      req_q    <= DEV_REQ;
      idle_cnt <= idle_nxt;
      gap_cnt  <= gap_nxt;
      latch_q  <= PORT_LATCH;
      clk_q    <= PORT_CLK;
      vde_q    <= VDE;
    end
  end

  // Read statistics: bits since latch, latch pulses per frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt       <= 6'd0;
      lat_cnt       <= 4'd0;
      lat_per_frame <= 4'd0;
    end else begin
      if (PORT_LATCH)
        bit_cnt <= 6'd0;
      else if (clk_rise && bit_cnt != 6'd63)
        bit_cnt <= bit_cnt + 6'd1;

      if (vde_rise) begin
        lat_per_frame <= lat_cnt;
        lat_cnt       <= latch_fall ? 4'd1 : 4'd0;
      end else if (latch_fall && lat_cnt != 4'd15) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
    end
  end

  // Zero-latency port routing; a disconnected port reads as nothing plugged in.
  assign connected = (state != DISC);

  always_comb begin
    DEV_LATCH = 4'b0000;
    DEV_CLK   = 4'b0000;
    PORT_DO   = 2'b00;
    PORT_P6   = 1'b1;
    if (connected) begin
      DEV_LATCH[dev_cur] = PORT_LATCH;
      DEV_CLK[dev_cur]   = PORT_CLK;
      PORT_DO            = DEV_DO[{dev_cur, 1'b0} +: 2];
      PORT_P6            = DEV_P6[dev_cur];
    end
  end

  assign DEV_CUR         = dev_cur;
  assign SWAPPING        = (state != RUN);
  assign BIT_CNT         = bit_cnt;
  assign LATCH_PER_FRAME = lat_per_frame;

endmodule
